nios2_cordic_sysid_checker: RTL and testbench

Avalon-MM read master that interrogates the system-ID slave after reset or on request. It reads the ID word at address 0 and the timestamp word at address 1, then compares both against build-time constants. It reports pass or fail to a status register, giving boot-time confirmation that the FPGA image matches the software build. It sits on the Qsys fabric alongside the Nios II data master and issues only reads.

---
 rtl/nios2_cordic_sysid_pkg.sv | 21 ++
 rtl/nios2_cordic_sysid_checker.sv | 164 ++++++++++++++++
 tb/tb_nios2_cordic_sysid_checker.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_cordic_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states, error codes, slave word addresses.
package nios2_cordic_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ID      = 2'd1;
    localparam logic [1:0] ERR_TS      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/nios2_cordic_sysid_checker.sv
// Avalon-MM read master that checks the system-ID slave's ID and timestamp words against build constants.
// Timestamp stage is present only when SYSID_CHECK_TS_EN is defined.
module nios2_cordic_sysid_checker
    import nios2_cordic_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1457789265,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RW = $clog2(MAX_RETRIES) + 1;

    state_t         state, state_nx;
    logic [TW-1:0]  tcnt, tcnt_nx;
    logic [RW-1:0]  rcnt, rcnt_nx;
    logic           pass_q, pass_nx;
    logic [1:0]     err_q, err_nx;
    logic [31:0]    id_q, id_nx;
    logic           timed_out, retry_ok;

`ifdef SYSID_CHECK_TS_EN
    logic [31:0]    ts_q, ts_nx;
    assign ts_value = ts_q;
`else
    logic [31:0]    unused_ts;
    assign unused_ts = EXPECTED_TS;
    assign ts_value  = '0;
`endif

    assign timed_out = (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign retry_ok  = (rcnt < RW'(MAX_RETRIES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            tcnt   <= '0;
            rcnt   <= '0;
            pass_q <= 1'b0;
            err_q  <= ERR_OK;
            id_q   <= '0;
`ifdef SYSID_CHECK_TS_EN
            ts_q   <= '0;
`endif
        end else begin
            state  <= state_nx;
            tcnt   <= tcnt_nx;
            rcnt   <= rcnt_nx;
            pass_q <= pass_nx;
            err_q  <= err_nx;
            id_q   <= id_nx;
`ifdef SYSID_CHECK_TS_EN
            ts_q   <= ts_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        rcnt_nx  = rcnt;
        pass_nx  = pass_q;
        err_nx   = err_q;
        id_nx    = id_q;
`ifdef SYSID_CHECK_TS_EN
        ts_nx    = ts_q;
`endif
        unique case (state)
            IDLE: if (start) begin
                state_nx = REQ_ID;
                pass_nx  = 1'b0;
                err_nx   = ERR_OK;
                rcnt_nx  = '0;
                tcnt_nx  = '0;
            end
            REQ_ID: if (!avm_waitrequest) begin
                state_nx = WAIT_ID;
                tcnt_nx  = '0;
            end
            // Data beats the timeout when both land on the same cycle.
            WAIT_ID: begin
                if (avm_readdatavalid) begin
                    id_nx = avm_readdata;
                    if (avm_readdata != EXPECTED_ID) begin
                        err_nx   = ERR_ID;
                        state_nx = DONE;
                    end else begin
`ifdef SYSID_CHECK_TS_EN
                        state_nx = REQ_TS;
                        rcnt_nx  = '0;
`else
                        state_nx = DONE;
`endif
                    end
                end else if (timed_out) begin
                    if (retry_ok) begin
                        rcnt_nx  = rcnt + 1'b1;
                        state_nx = REQ_ID;
                    end else begin
                        err_nx   = ERR_TIMEOUT;
                        state_nx = DONE;
                    end
                end else begin
                    tcnt_nx = tcnt + 1'b1;
                end
            end
`ifdef SYSID_CHECK_TS_EN
            REQ_TS: if (!avm_waitrequest) begin
                state_nx = WAIT_TS;
                tcnt_nx  = '0;
            end
            WAIT_TS: begin
                if (avm_readdatavalid) begin
                    ts_nx    = avm_readdata;
                    err_nx   = (avm_readdata != EXPECTED_TS) ? ERR_TS : ERR_OK;
                    state_nx = DONE;
                end else if (timed_out) begin
                    if (retry_ok) begin
                        rcnt_nx  = rcnt + 1'b1;
                        state_nx = REQ_TS;
                    end else begin
                        err_nx   = ERR_TIMEOUT;
                        state_nx = DONE;
                    end
                end else begin
                    tcnt_nx = tcnt + 1'b1;
                end
            end
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Result becomes visible together with the done pulse.
        if (state_nx == DONE && state != DONE)
            pass_nx = (err_nx == ERR_OK);

        avm_read    = (state == REQ_ID) || (state == REQ_TS);
        avm_address = (state == REQ_TS || state == WAIT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        busy        = (state != IDLE) && (state != DONE);
        done        = (state == DONE);
    end

    assign pass     = pass_q;
    assign err_code = err_q;
    assign id_value = id_q;

endmodule

// File: tb/tb_nios2_cordic_sysid_checker.sv
// Scoreboard bench for the system-ID checker: directed slave scenarios, queued expectations checked on done.
module tb_nios2_cordic_sysid_checker;

    localparam int TO = 4;
    localparam int MR = 3;
    localparam logic [31:0] GOOD_TS = 32'd1457789265;
`ifdef SYSID_CHECK_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_address, avm_read, busy, done, pass;
    logic [1:0]  err_code;
    logic [31:0] id_value, ts_value;

    always #5 clock = ~clock;

    nios2_cordic_sysid_checker #(
        .EXPECTED_ID(32'd0), .EXPECTED_TS(GOOD_TS),
        .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .done(done), .pass(pass), .err_code(err_code),
        .id_value(id_value), .ts_value(ts_value)
    );

    typedef struct packed {
        logic        pass;
        logic [1:0]  err;
        logic [31:0] id;
        logic [31:0] ts;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int tag = 0;

    // slave model configuration and observation
    int          wait_cfg = 0;
    bit          resp_id = 1'b1, resp_ts = 1'b1;
    logic [31:0] id_data = '0, ts_data = GOOD_TS;
    int          acc0 = 0, acc1 = 0, stalls = 0, wcnt = 0;
    bit          pending = 1'b0, paddr = 1'b0, stall_bad = 1'b0, stall_addr = 1'b0, inject = 1'b0;

    function automatic exp_t mk(input logic p, input logic [1:0] e, input logic [31:0] id, input logic [31:0] ts);
        exp_t r;
        r.pass = p; r.err = e; r.id = id; r.ts = ts;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Avalon slave: decisions made on the falling edge, seen by the DUT on the next rising edge.
    initial forever begin
        @(negedge clock);
        if (!reset_n) begin
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
            pending = 1'b0;
            wcnt    = 0;
        end else begin
            avm_readdatavalid = 1'b0;
            if (inject) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = 32'hDEAD_BEEF;
                inject = 1'b0;
            end
            if (pending) begin
                avm_readdatavalid = paddr ? resp_ts : resp_id;
                avm_readdata      = paddr ? ts_data : id_data;
                pending = 1'b0;
            end
            if (avm_read) begin
                if (wcnt < wait_cfg) begin
                    if (wcnt == 0) stall_addr = avm_address;
                    else if (avm_address !== stall_addr) stall_bad = 1'b1;
                    avm_waitrequest = 1'b1;
                    wcnt++;
                    stalls++;
                end else begin
                    if (wcnt != 0 && avm_address !== stall_addr) stall_bad = 1'b1;
                    avm_waitrequest = 1'b0;
                    wcnt    = 0;
                    pending = 1'b1;
                    paddr   = avm_address;
                    if (avm_address) acc1++; else acc0++;
                end
            end else begin
                if (wcnt != 0) stall_bad = 1'b1;
                avm_waitrequest = 1'b0;
            end
        end
    end

    // Monitor: every done pulse is matched against the oldest queued expectation.
    initial forever begin
        @(negedge clock);
        if (reset_n && done) begin
            checks++;
            tag++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected#%0d got pass=%0d err=%0d expected no done", tag, pass, err_code);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({pass, err_code, id_value, ts_value} !== e) begin
                    errors++;
                    $display("FAIL done_result#%0d got pass=%0d err=%0d id=%h ts=%h expected pass=%0d err=%0d id=%h ts=%h",
                             tag, pass, err_code, id_value, ts_value, e.pass, e.err, e.id, e.ts);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    task automatic run_check(input string name, input exp_t e);
        int n;
        acc0 = 0; acc1 = 0; stalls = 0; stall_bad = 1'b0;
        q.push_back(e);
        pulse_start();
        n = 0;
        while (!done && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no done expected done within 200 cycles", name);
            q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check("reset_ctrl", 64'({avm_read, avm_address, busy, done, pass, err_code}), 64'd0);
        check("reset_data", {id_value, ts_value}, 64'd0);
        @(negedge clock) reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // good ID and timestamp, zero-wait slave
        run_check("good", mk(1'b1, 2'd0, 32'd0, TS_EN ? GOOD_TS : 32'd0));
        check("good_reads_addr0", 64'(acc0), 64'd1);
        check("good_reads_addr1", 64'(acc1), TS_EN ? 64'd1 : 64'd0);

        // ID mismatch: no timestamp read
        id_data = 32'h0000_0001;
        run_check("id_bad", mk(1'b0, 2'd1, 32'd1, TS_EN ? GOOD_TS : 32'd0));
        check("id_bad_no_addr1", 64'(acc1), 64'd0);

        // waitrequest stall of 5 cycles per request
        id_data = 32'd0;
        wait_cfg = 5;
        run_check("stall", mk(1'b1, 2'd0, 32'd0, TS_EN ? GOOD_TS : 32'd0));
        check("stall_one_accept", 64'(acc0), 64'd1);
        check("stall_cycles", 64'(stalls), TS_EN ? 64'd10 : 64'd5);
        check("stall_stable", 64'(stall_bad), 64'd0);
        wait_cfg = 0;

        // slave never responds: 1 + MAX_RETRIES requests then timeout
        resp_id = 1'b0;
        run_check("timeout", mk(1'b0, 2'd3, 32'd0, TS_EN ? GOOD_TS : 32'd0));
        check("timeout_requests", 64'(acc0), 64'(MR + 1));
        check("timeout_addr1", 64'(acc1), 64'd0);
        resp_id = 1'b1;

`ifdef SYSID_CHECK_TS_EN
        ts_data = 32'h1234_5678;
        run_check("ts_bad", mk(1'b0, 2'd2, 32'd0, 32'h1234_5678));
        ts_data = GOOD_TS;
`endif

        // reset during the last wait stage, then a late response
        if (TS_EN) resp_ts = 1'b0; else resp_id = 1'b0;
        acc0 = 0; acc1 = 0;
        pulse_start();
        n = 0;
        while ((TS_EN ? acc1 : acc0) == 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL midreset_reach got no request expected request within 100 cycles");
        end
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check("midreset_outputs",
                 64'({avm_read, avm_address, busy, done, pass, err_code}) ^ {id_value, ts_value}, 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        inject = 1'b1;
        repeat (4) @(negedge clock);
        check("late_rdv_ignored", 64'({avm_read, busy, done, pass, err_code}) | 64'(id_value) | 64'(ts_value), 64'd0);
        resp_id = 1'b1; resp_ts = 1'b1;

        run_check("after_reset", mk(1'b1, 2'd0, 32'd0, TS_EN ? GOOD_TS : 32'd0));
        check("after_reset_queue", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
